// File: rtl/i2s_mic_rx.sv
// I2S master receiver for a PCM MEMS microphone.
// Generates bclk/ws from mclk, deserialises one channel slot MSB-first with
// the I2S one-bit delay, and buffers samples in a first-word-fall-through FIFO
// with a sticky overflow flag.
module i2s_mic_rx #(
    parameter int CLK_DIV     = 4,
    parameter int SAMPLE_BITS = 24,
    parameter int CHANNEL     = 0,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          mclk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          din,
    output logic                          bclk,
    output logic                          ws,
    output logic [SAMPLE_BITS-1:0]        sample_data,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fill,
    output logic                          overflow
);

    localparam int DCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int FW  = AW + 1;

    localparam logic [DCW-1:0] DC_LAST  = DCW'(CLK_DIV - 1);
    localparam logic [4:0]     K_LAST   = 5'(SAMPLE_BITS);
    localparam logic           CH_SEL   = (CHANNEL != 0) ? 1'b1 : 1'b0;
    localparam logic [FW-1:0]  FULL_CNT = FW'(FIFO_DEPTH);

    // Clock generation and capture state
    logic [DCW-1:0]         dc_q, dc_d;
    logic                   bclk_q, bclk_d;
    logic                   ws_q, ws_d;
    logic [5:0]             bc_q, bc_d;
    logic [SAMPLE_BITS-1:0] sh_q, sh_d;
    logic                   push_q, push_d;
    logic [SAMPLE_BITS-1:0] push_data_q, push_data_d;

    // FIFO state
    logic [SAMPLE_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [SAMPLE_BITS-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]          cnt_q, cnt_d;
    logic                   overflow_q, overflow_d;

    // Combinational helpers
    logic                   tick_s;
    logic                   capture_s;
    logic                   last_s;
    logic [5:0]             bc_inc_s;
    logic [SAMPLE_BITS-1:0] sh_next_s;
    logic                   valid_s;
    logic                   full_s;
    logic                   pop_s;
    logic                   wr_en_s;
    logic                   ovf_set_s;

    assign tick_s    = enable && (dc_q == DC_LAST);
    assign bc_inc_s  = bc_q + 6'd1;
    // Slot-relative bit k=1 carries the MSB (one-bit I2S delay after ws edge).
    assign capture_s = (bc_q[5] == CH_SEL) && (bc_q[4:0] >= 5'd1) && (bc_q[4:0] <= K_LAST);
    assign last_s    = capture_s && (bc_q[4:0] == K_LAST);
    assign sh_next_s = SAMPLE_BITS'({sh_q, din});

    assign valid_s   = (cnt_q != {FW{1'b0}});
    assign full_s    = (cnt_q == FULL_CNT);
    assign pop_s     = valid_s && sample_ready;
    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign wr_en_s   = push_q && (!full_s || pop_s);
    assign ovf_set_s = push_q && full_s && !pop_s;

    // Next state for divider, bit counter, word select and shift register
    always_comb begin
        dc_d        = dc_q;
        bclk_d      = bclk_q;
        ws_d        = ws_q;
        bc_d        = bc_q;
        sh_d        = sh_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        if (!enable) begin
            dc_d   = {DCW{1'b0}};
            bclk_d = 1'b0;
            ws_d   = 1'b0;
            bc_d   = 6'd0;
            sh_d   = {SAMPLE_BITS{1'b0}};
        end else if (tick_s) begin
            dc_d   = {DCW{1'b0}};
            bclk_d = ~bclk_q;
            if (bclk_q) begin
                // Falling bclk: advance frame position, ws follows the slot bit.
                bc_d = bc_inc_s;
                ws_d = bc_inc_s[5];
            end else if (capture_s) begin
                // Rising bclk: sample din into the shift register.
                sh_d = sh_next_s;
                if (last_s) begin
                    push_d      = 1'b1;
                    push_data_d = sh_next_s;
                end else begin
                    push_data_d = push_data_q;
                end
            end else begin
                sh_d = sh_q;
            end
        end else begin
            dc_d = dc_q + DCW'(1);
        end
    end

    // Next state for FIFO storage, pointers, occupancy and sticky overflow
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q | ovf_set_s;
        if (wr_en_s) begin
            mem_d[wr_ptr_q] = push_data_q;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, pop_s})
            2'b10:   cnt_d = cnt_q + FW'(1);
            2'b01:   cnt_d = cnt_q - FW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control registers with synchronous reset
    always_ff @(posedge mclk) begin
        if (reset) begin
            dc_q        <= {DCW{1'b0}};
            bclk_q      <= 1'b0;
            ws_q        <= 1'b0;
            bc_q        <= 6'd0;
            sh_q        <= {SAMPLE_BITS{1'b0}};
            push_q      <= 1'b0;
            push_data_q <= {SAMPLE_BITS{1'b0}};
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            cnt_q       <= {FW{1'b0}};
            overflow_q  <= 1'b0;
        end else begin
            dc_q        <= dc_d;
            bclk_q      <= bclk_d;
            ws_q        <= ws_d;
            bc_q        <= bc_d;
            sh_q        <= sh_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    // FIFO storage array; contents are don't-care while the count is zero
    always_ff @(posedge mclk) begin
        mem_q <= mem_d;
    end

    assign bclk         = bclk_q;
    assign ws           = ws_q;
    assign sample_valid = valid_s;
    assign fill         = cnt_q;
    assign overflow     = overflow_q;
    assign sample_data  = valid_s ? mem_q[rd_ptr_q] : {SAMPLE_BITS{1'b0}};

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Directed testbench for i2s_mic_rx: a left-slot and a right-slot instance
// share one behavioural microphone that shifts data out after each bclk fall.
module tb_i2s_mic_rx;

    logic        mclk;
    logic        reset;
    logic        enable;
    logic        din;
    logic        bclk_l, ws_l, valid_l, ready_l, ovf_l;
    logic        bclk_r, ws_r, valid_r, ready_r, ovf_r;
    logic [23:0] data_l, data_r;
    logic [3:0]  fill_l, fill_r;

    int checks = 0;
    int errors = 0;

    logic [23:0] lw [16];
    logic [23:0] rw [16];
    logic        filler;
    int          mic_pos;
    logic        mic_prev;

    i2s_mic_rx #(.CLK_DIV(2), .SAMPLE_BITS(24), .CHANNEL(0), .FIFO_DEPTH(8)) u_left (
        .mclk(mclk), .reset(reset), .enable(enable), .din(din),
        .bclk(bclk_l), .ws(ws_l), .sample_data(data_l), .sample_valid(valid_l),
        .sample_ready(ready_l), .fill(fill_l), .overflow(ovf_l)
    );

    i2s_mic_rx #(.CLK_DIV(2), .SAMPLE_BITS(24), .CHANNEL(1), .FIFO_DEPTH(8)) u_right (
        .mclk(mclk), .reset(reset), .enable(enable), .din(din),
        .bclk(bclk_r), .ws(ws_r), .sample_data(data_r), .sample_valid(valid_r),
        .sample_ready(ready_r), .fill(fill_r), .overflow(ovf_r)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    // Frame bit 0 and 25..31 / 32 and 57..63 carry the filler value.
    function automatic logic mic_bit(input int pos);
        int f;
        int b;
        f = (pos / 64) % 16;
        b = pos % 64;
        if (b >= 1 && b <= 24) return lw[f][24 - b];
        else if (b >= 33 && b <= 56) return rw[f][56 - b];
        else return filler;
    endfunction

    // Microphone model: counts bclk falls and presents the next frame bit
    always @(negedge mclk) begin
        if (reset || !enable) begin
            mic_pos  <= 0;
            mic_prev <= 1'b0;
            din      <= mic_bit(0);
        end else begin
            mic_pos  <= (mic_prev && !bclk_l) ? mic_pos + 1 : mic_pos;
            mic_prev <= bclk_l;
            din      <= mic_bit((mic_prev && !bclk_l) ? mic_pos + 1 : mic_pos);
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) @(negedge mclk);
    endtask

    // Leaves reset low at a negedge; the next posedge is edge 1.
    task automatic do_reset();
        @(negedge mclk);
        reset   = 1'b1;
        enable  = 1'b0;
        ready_l = 1'b0;
        ready_r = 1'b0;
        wait_edges(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; ready_l = 1'b0; ready_r = 1'b0;
        wait_edges(3);
        checks++; if (bclk_l !== 1'b0) begin errors++; $display("FAIL reset_bclk: got %b expected 0", bclk_l); end
        checks++; if (ws_l !== 1'b0) begin errors++; $display("FAIL reset_ws: got %b expected 0", ws_l); end
        checks++; if (valid_l !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_l); end
        checks++; if (fill_l !== 4'd0) begin errors++; $display("FAIL reset_fill: got %0d expected 0", fill_l); end
        checks++; if (ovf_l !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", ovf_l); end
        checks++; if (data_l !== 24'h000000) begin errors++; $display("FAIL reset_data: got %h expected 000000", data_l); end
    endtask

    task automatic test_dividers();
        logic pb, pw, fell;
        int   first_rise, last_rise, per_bad, ws_bad, falls, ws_rise1, ws_rise2, falls_at_ws;
        pb = 1'b0; pw = 1'b0;
        first_rise = -1; last_rise = -1; per_bad = 0; ws_bad = 0; falls = 0;
        ws_rise1 = -1; ws_rise2 = -1; falls_at_ws = -1;
        do_reset();
        enable = 1'b1;
        for (int e = 1; e <= 400; e++) begin
            @(negedge mclk);
            fell = pb && !bclk_l;
            if (!pb && bclk_l) begin
                if (first_rise < 0) first_rise = e;
                else if (e - last_rise != 4) per_bad++;
                last_rise = e;
            end
            if (fell) falls++;
            if (ws_l !== pw) begin
                if (!fell) ws_bad++;
                if (ws_l === 1'b1) begin
                    if (ws_rise1 < 0) begin ws_rise1 = e; falls_at_ws = falls; end
                    else if (ws_rise2 < 0) ws_rise2 = e;
                end
            end
            pb = bclk_l; pw = ws_l;
        end
        checks++; if (first_rise != 2) begin errors++; $display("FAIL div_first_rise: got %0d expected 2", first_rise); end
        checks++; if (per_bad != 0) begin errors++; $display("FAIL div_bclk_period: got %0d bad periods expected 0", per_bad); end
        checks++; if (falls != 100) begin errors++; $display("FAIL div_fall_count: got %0d expected 100", falls); end
        checks++; if (ws_bad != 0) begin errors++; $display("FAIL div_ws_edge: got %0d off-fall changes expected 0", ws_bad); end
        checks++; if (ws_rise1 != 128) begin errors++; $display("FAIL div_ws_first_rise: got %0d expected 128", ws_rise1); end
        checks++; if (falls_at_ws != 32) begin errors++; $display("FAIL div_ws_rise_fall_no: got %0d expected 32", falls_at_ws); end
        checks++; if (ws_rise2 - ws_rise1 != 256) begin errors++; $display("FAIL div_ws_period: got %0d expected 256", ws_rise2 - ws_rise1); end
        wait_edges(2);
        enable = 1'b0;
        wait_edges(1);
        checks++; if (bclk_l !== 1'b0) begin errors++; $display("FAIL div_disable_bclk: got %b expected 0", bclk_l); end
        checks++; if (ws_l !== 1'b0) begin errors++; $display("FAIL div_disable_ws: got %b expected 0", ws_l); end
    endtask

    task automatic test_capture_left();
        do_reset();
        lw[0] = 24'hA5C3F1; rw[0] = 24'hFFFFFF; filler = 1'b1;
        enable = 1'b1;
        wait_edges(98);
        checks++; if (valid_l !== 1'b0) begin errors++; $display("FAIL left_early_valid: got %b expected 0", valid_l); end
        wait_edges(1);
        checks++; if (valid_l !== 1'b1) begin errors++; $display("FAIL left_valid: got %b expected 1", valid_l); end
        checks++; if (data_l !== 24'hA5C3F1) begin errors++; $display("FAIL left_data: got %h expected a5c3f1", data_l); end
        wait_edges(141);
        checks++; if (fill_l !== 4'd1) begin errors++; $display("FAIL left_no_right_sample: got fill %0d expected 1", fill_l); end
        checks++; if (data_r !== 24'hFFFFFF) begin errors++; $display("FAIL left_run_right_data: got %h expected ffffff", data_r); end
    endtask

    task automatic test_capture_right();
        do_reset();
        lw[0] = 24'h123456; rw[0] = 24'h800001; filler = 1'b1;
        enable = 1'b1;
        wait_edges(99);
        checks++; if (data_l !== 24'h123456) begin errors++; $display("FAIL right_run_left_data: got %h expected 123456", data_l); end
        checks++; if (valid_r !== 1'b0) begin errors++; $display("FAIL right_early_valid: got %b expected 0", valid_r); end
        wait_edges(127);
        checks++; if (valid_r !== 1'b0) begin errors++; $display("FAIL right_valid_before_write: got %b expected 0", valid_r); end
        wait_edges(1);
        checks++; if (valid_r !== 1'b1) begin errors++; $display("FAIL right_valid: got %b expected 1", valid_r); end
        checks++; if (data_r !== 24'h800001) begin errors++; $display("FAIL right_data: got %h expected 800001", data_r); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int f = 0; f < 16; f++) begin
            lw[f] = 24'h0F0F00 + 24'(f) * 24'h111111;
            rw[f] = ~lw[f];
        end
        filler = 1'b0;
        enable = 1'b1;
        wait_edges(2146);
        checks++; if (fill_l !== 4'd8) begin errors++; $display("FAIL ovf_fill_before: got %0d expected 8", fill_l); end
        checks++; if (ovf_l !== 1'b0) begin errors++; $display("FAIL ovf_flag_before: got %b expected 0", ovf_l); end
        wait_edges(1);
        checks++; if (fill_l !== 4'd8) begin errors++; $display("FAIL ovf_fill: got %0d expected 8", fill_l); end
        checks++; if (ovf_l !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", ovf_l); end
        enable = 1'b0;
        wait_edges(1);
        ready_l = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (valid_l !== 1'b1 || data_l !== lw[i]) begin
                errors++;
                $display("FAIL ovf_drain_%0d: got valid %b data %h expected valid 1 data %h", i, valid_l, data_l, lw[i]);
            end
            @(negedge mclk);
        end
        ready_l = 1'b0;
        checks++; if (fill_l !== 4'd0) begin errors++; $display("FAIL ovf_drained_fill: got %0d expected 0", fill_l); end
        checks++; if (valid_l !== 1'b0) begin errors++; $display("FAIL ovf_drained_valid: got %b expected 0", valid_l); end
        checks++; if (ovf_l !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", ovf_l); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        enable = 1'b1;
        wait_edges(2146);
        checks++; if (fill_l !== 4'd8) begin errors++; $display("FAIL b2b_full: got %0d expected 8", fill_l); end
        ready_l = 1'b1;
        wait_edges(1);
        checks++; if (fill_l !== 4'd8) begin errors++; $display("FAIL b2b_fill: got %0d expected 8", fill_l); end
        checks++; if (ovf_l !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b expected 0", ovf_l); end
        checks++; if (data_l !== lw[1]) begin errors++; $display("FAIL b2b_head: got %h expected %h", data_l, lw[1]); end
        enable = 1'b0;
        wait_edges(7);
        checks++; if (data_l !== lw[8]) begin errors++; $display("FAIL b2b_tail: got %h expected %h", data_l, lw[8]); end
        checks++; if (fill_l !== 4'd1) begin errors++; $display("FAIL b2b_tail_fill: got %0d expected 1", fill_l); end
        ready_l = 1'b0;
    endtask

    task automatic test_enable_reset_mid();
        do_reset();
        lw[0] = 24'h6B2D4E; lw[1] = 24'h0C0FFE; filler = 1'b1;
        enable = 1'b1;
        wait_edges(307);
        checks++; if (bclk_l !== 1'b1) begin errors++; $display("FAIL mid_bclk_high: got %b expected 1", bclk_l); end
        enable = 1'b0;
        wait_edges(1);
        checks++; if (bclk_l !== 1'b0) begin errors++; $display("FAIL mid_dis_bclk: got %b expected 0", bclk_l); end
        checks++; if (ws_l !== 1'b0) begin errors++; $display("FAIL mid_dis_ws: got %b expected 0", ws_l); end
        wait_edges(120);
        checks++; if (fill_l !== 4'd1) begin errors++; $display("FAIL mid_dis_fill: got %0d expected 1", fill_l); end
        checks++; if (valid_l !== 1'b1 || data_l !== 24'h6B2D4E) begin errors++; $display("FAIL mid_dis_head: got valid %b data %h expected 1 6b2d4e", valid_l, data_l); end
        lw[0] = 24'h3C5A96;
        enable = 1'b1;
        wait_edges(51);
        reset = 1'b1;
        wait_edges(1);
        checks++; if (bclk_l !== 1'b0 || ws_l !== 1'b0) begin errors++; $display("FAIL mid_rst_clocks: got bclk %b ws %b expected 0 0", bclk_l, ws_l); end
        checks++; if (valid_l !== 1'b0 || fill_l !== 4'd0) begin errors++; $display("FAIL mid_rst_fifo: got valid %b fill %0d expected 0 0", valid_l, fill_l); end
        checks++; if (data_l !== 24'h000000 || ovf_l !== 1'b0) begin errors++; $display("FAIL mid_rst_data: got data %h ovf %b expected 000000 0", data_l, ovf_l); end
        wait_edges(1);
        reset = 1'b0;
        wait_edges(98);
        checks++; if (valid_l !== 1'b0) begin errors++; $display("FAIL mid_restart_early: got %b expected 0", valid_l); end
        wait_edges(1);
        checks++; if (valid_l !== 1'b1 || data_l !== 24'h3C5A96) begin errors++; $display("FAIL mid_restart_data: got valid %b data %h expected 1 3c5a96", valid_l, data_l); end
        checks++; if (fill_l !== 4'd1) begin errors++; $display("FAIL mid_restart_fill: got %0d expected 1", fill_l); end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; ready_l = 1'b0; ready_r = 1'b0; filler = 1'b0;
        for (int f = 0; f < 16; f++) begin
            lw[f] = 24'h000000;
            rw[f] = 24'h000000;
        end
        test_reset();
        test_dividers();
        test_capture_left();
        test_capture_right();
        test_overflow();
        test_back_to_back();
        test_enable_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
